coffee_vend_ctrl: RTL and testbench
===================================

COFFEE_VEND_CTRL -- requirements
Module: coffee_vend_ctrl

Interface
REQ-001 Parameter N_PRODUCTS, default 4: number of selectable products, 2..8.
REQ-002 Parameter CREDIT_W, default 4: width of credit, price and change values.
REQ-003 Parameter PRICE_LIST, default {7,5,4,3} packed as N_PRODUCTS x CREDIT_W: price of product i at slice i.
REQ-004 Parameter DISPENSE_CYCLES, default 50: cycles dispense_active stays high per sale, 1..65535.
REQ-005 Parameter SEL_W, default $clog2(N_PRODUCTS): product_sel width.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 coin_valid  input  1  one coin presented this cycle.
REQ-009 coin_value  input  CREDIT_W  value of the presented coin.
REQ-010 product_sel  input  SEL_W  product index, sampled when buy=1.
REQ-011 buy  input  1  purchase request, one-cycle pulse.
REQ-012 cancel  input  1  refund request, one-cycle pulse.
REQ-013 credit  output  CREDIT_W  accumulated credit, registered.
REQ-014 change  output  CREDIT_W  refund or change amount, valid while change_valid=1.
REQ-015 change_valid  output  1  one-cycle pulse qualifying change.
REQ-016 dispense_active  output  1  high for exactly DISPENSE_CYCLES cycles per sale.
REQ-017 coin_reject  output  1  one-cycle pulse, registered one cycle after a refused coin.
REQ-018 sel_error  output  1  one-cycle pulse, registered one cycle after a refused buy.

Function
REQ-019 The FSM SHALL have three states: COLLECT (reset state), DISPENSE and PAYOUT.
REQ-020 In COLLECT, coin_valid=1 SHALL add coin_value to credit next cycle; a sum above 2^CREDIT_W-1 SHALL leave credit unchanged and pulse coin_reject.
REQ-021 In COLLECT, buy=1 with product_sel < N_PRODUCTS and credit >= price SHALL latch change = credit - price, clear credit and enter DISPENSE next cycle.
REQ-022 buy=1 with credit < price or product_sel >= N_PRODUCTS SHALL pulse sel_error and leave credit and state unchanged.
REQ-023 In COLLECT, cancel=1 SHALL enter PAYOUT with change = credit and clear credit; with credit=0 it SHALL do nothing.
REQ-024 Priority within one COLLECT cycle SHALL be cancel > buy > coin; a coin arriving in the same cycle as an accepted buy or cancel SHALL be refused with coin_reject.
REQ-025 DISPENSE SHALL hold dispense_active=1 for exactly DISPENSE_CYCLES cycles using an internal down-counter, then enter PAYOUT.
REQ-026 PAYOUT SHALL last one cycle: change_valid=1 only when change is non-zero; then return to COLLECT.
REQ-027 Coins in DISPENSE or PAYOUT SHALL be refused with coin_reject; buy and cancel there SHALL be ignored without error.
REQ-028 change SHALL hold its last value between pulses; it SHALL be compared only when change_valid=1.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately give: state=COLLECT, credit=0, change=0, and change_valid, dispense_active, coin_reject, sel_error all 0, with counters cleared.
REQ-030 Reset during DISPENSE SHALL abort the sale with no change payout; the credit already consumed is lost by design.

Configuration
REQ-031 Macro REFUND_TIMEOUT_EN defined: in COLLECT with credit > 0, 256 consecutive cycles without coin_valid, buy or cancel SHALL act as cancel. The idle counter SHALL restart on any of these events.
REQ-032 REFUND_TIMEOUT_EN undefined: no idle counter SHALL exist, and credit SHALL be held indefinitely.

Verification
REQ-033 Defaults; coins 2,2,1, then buy sel=2 (price 5) -> credit 5; dispense_active high 50 cycles; no change_valid.
REQ-034 Coins 4,4, then buy sel=3 (price 7) -> 50 dispense cycles, then change_valid pulse with change=1; credit=0.
REQ-035 Credit 3, buy sel=1 (price 4) -> sel_error pulse; credit stays 3; cancel -> change_valid with change=3.
REQ-036 Credit 14, coin 3 -> coin_reject pulse, credit stays 14; coin during DISPENSE -> coin_reject.
REQ-037 Assert rst_n mid-DISPENSE at cycle 20 -> all outputs 0 asynchronously; state COLLECT after release.
REQ-038 REFUND_TIMEOUT_EN defined, credit 2, idle 256 cycles -> change_valid with change=2; undefined -> no pulse.

Source files
------------

// File: rtl/coffee_vend_ctrl.sv
// Coffee vending controller: collects coins, sells one of N_PRODUCTS, times the dispense and pays change.
// Optional macro REFUND_TIMEOUT_EN refunds idle credit after 256 quiet cycles.
module coffee_vend_ctrl #(
   parameter int N_PRODUCTS = 4,
   parameter int CREDIT_W = 4,
   parameter logic [N_PRODUCTS*CREDIT_W-1:0] PRICE_LIST = {4'd7, 4'd5, 4'd4, 4'd3},
   parameter int DISPENSE_CYCLES = 50,
   parameter int SEL_W = $clog2(N_PRODUCTS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                coin_valid,
   input  logic [CREDIT_W-1:0] coin_value,
   input  logic [SEL_W-1:0]    product_sel,
   input  logic                buy,
   input  logic                cancel,
   output logic [CREDIT_W-1:0] credit,
   output logic [CREDIT_W-1:0] change,
   output logic                change_valid,
   output logic                dispense_active,
   output logic                coin_reject,
   output logic                sel_error,
   output logic [1:0]          state_dbg
);

   // Handshake: coin_valid, buy and cancel are valid-only one-cycle strobes with no ready;
   // every strobe is consumed in the cycle it is seen, and refusals are reported one cycle later.

   typedef enum logic [1:0] {
      COLLECT  = 2'd0,
      DISPENSE = 2'd1,
      PAYOUT   = 2'd2
   } state_t;

   localparam logic [15:0] CNT_LOAD = 16'(DISPENSE_CYCLES - 1);

   state_t              state, state_nxt;
   logic [CREDIT_W-1:0] credit_nxt, change_nxt;
   logic [15:0]         cnt, cnt_nxt;
   logic                coin_reject_nxt, sel_error_nxt;
   logic [CREDIT_W:0]   coin_sum;
   logic [CREDIT_W-1:0] price;
   logic                sel_ok, buy_ok, cancel_go, timeout_go;

   assign coin_sum = {1'b0, credit} + {1'b0, coin_value};
   assign sel_ok   = (32'(product_sel) < N_PRODUCTS);
   assign price    = sel_ok ? PRICE_LIST[product_sel*CREDIT_W +: CREDIT_W] : '0;
   assign buy_ok   = sel_ok && (credit >= price);
   assign cancel_go = (cancel && (credit != '0)) || timeout_go;

`ifdef REFUND_TIMEOUT_EN
   logic [7:0] idle_cnt, idle_nxt;
   logic       idle_cycle;

   // Counts only quiet cycles while holding credit; any strobe or leaving COLLECT restarts it.
   assign idle_cycle = (state == COLLECT) && (credit != '0) && !coin_valid && !buy && !cancel;
   assign timeout_go = idle_cycle && (idle_cnt == 8'd255);
   assign idle_nxt   = idle_cycle ? idle_cnt + 8'd1 : 8'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) idle_cnt <= 8'd0;
      else        idle_cnt <= idle_nxt;
   end
`else
   assign timeout_go = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= COLLECT;
         credit      <= '0;
         change      <= '0;
         cnt         <= 16'd0;
         coin_reject <= 1'b0;
         sel_error   <= 1'b0;
      end else begin
         state       <= state_nxt;
         credit      <= credit_nxt;
         change      <= change_nxt;
         cnt         <= cnt_nxt;
         coin_reject <= coin_reject_nxt;
         sel_error   <= sel_error_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      credit_nxt      = credit;
      change_nxt      = change;
      cnt_nxt         = cnt;
      coin_reject_nxt = 1'b0;
      sel_error_nxt   = 1'b0;
      case (state)
         COLLECT: begin
            // Priority cancel > buy > coin; a coin never lands alongside a cancel or a buy.
            if (cancel_go) begin
               change_nxt      = credit;
               credit_nxt      = '0;
               state_nxt       = PAYOUT;
               coin_reject_nxt = coin_valid;
            end else if (buy) begin
               coin_reject_nxt = coin_valid;
               if (buy_ok) begin
                  change_nxt = credit - price;
                  credit_nxt = '0;
                  cnt_nxt    = CNT_LOAD;
                  state_nxt  = DISPENSE;
               end else begin
                  sel_error_nxt = 1'b1;
               end
            end else if (coin_valid) begin
               if (coin_sum[CREDIT_W]) coin_reject_nxt = 1'b1;
               else                    credit_nxt      = coin_sum[CREDIT_W-1:0];
            end
         end
         DISPENSE: begin
            coin_reject_nxt = coin_valid;
            if (cnt == 16'd0) state_nxt = PAYOUT;
            else              cnt_nxt   = cnt - 16'd1;
         end
         PAYOUT: begin
            coin_reject_nxt = coin_valid;
            state_nxt       = COLLECT;
         end
         default: state_nxt = COLLECT;
      endcase
   end

   always_comb begin
      dispense_active = (state == DISPENSE);
      change_valid    = (state == PAYOUT) && (change != '0);
      state_dbg       = state;
   end

endmodule

// File: tb/tb_coffee_vend_ctrl.sv
// Directed bench for coffee_vend_ctrl; payouts are also tracked by an expected-change queue.
// Define REFUND_TIMEOUT_EN for both bench and RTL to exercise the refund timeout.
module tb_coffee_vend_ctrl;

   logic       clk;
   logic       rst_n;
   logic       coin_valid;
   logic [3:0] coin_value;
   logic [1:0] product_sel;
   logic       buy;
   logic       cancel;
   logic [3:0] credit;
   logic [3:0] change;
   logic       change_valid;
   logic       dispense_active;
   logic       coin_reject;
   logic       sel_error;
   logic [1:0] state_dbg;

   int assert_cnt = 0;
   int fail_cnt = 0;
   logic [3:0] exp_q[$];

   coffee_vend_ctrl dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .coin_valid      (coin_valid),
      .coin_value      (coin_value),
      .product_sel     (product_sel),
      .buy             (buy),
      .cancel          (cancel),
      .credit          (credit),
      .change          (change),
      .change_valid    (change_valid),
      .dispense_active (dispense_active),
      .coin_reject     (coin_reject),
      .sel_error       (sel_error),
      .state_dbg       (state_dbg)
   );

   // clock/reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard: every change_valid pulse must match the oldest expected payout
   always @(negedge clk) begin
      if (change_valid) begin
         assert_cnt++;
         if (exp_q.size() == 0) begin
            $display("FAIL payout_sb: unexpected change_valid with change=%0d", change);
            fail_cnt++;
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            if (change !== e) begin
               $display("FAIL payout_sb: change=%0d expected %0d", change, e);
               fail_cnt++;
            end
         end
      end
   end

   // driver tasks: each returns 1 time unit after the edge that consumed the stimulus
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic insert_coin(input logic [3:0] v);
      coin_valid = 1'b1;
      coin_value = v;
      step();
      coin_valid = 1'b0;
      coin_value = 4'd0;
   endtask

   task automatic do_buy(input logic [1:0] sel);
      buy = 1'b1;
      product_sel = sel;
      step();
      buy = 1'b0;
   endtask

   task automatic do_cancel();
      cancel = 1'b1;
      step();
      cancel = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      coin_valid = 1'b0;
      coin_value = 4'd0;
      product_sel = 2'd0;
      buy = 1'b0;
      cancel = 1'b0;
      #3;
      assert_cnt++;
      if ({credit, change, change_valid, dispense_active, coin_reject, sel_error, state_dbg} !== 14'd0) begin
         $display("FAIL reset_outputs: credit=%0d change=%0d cv=%b da=%b cr=%b se=%b st=%0d expected all 0",
                  credit, change, change_valid, dispense_active, coin_reject, sel_error, state_dbg);
         fail_cnt++;
      end
      #9 rst_n = 1'b1;
      step();
      assert_cnt++;
      if (state_dbg !== 2'd0 || credit !== 4'd0) begin
         $display("FAIL reset_release: state=%0d credit=%0d expected 0/0", state_dbg, credit);
         fail_cnt++;
      end
   endtask

   task automatic test_exact_buy();
      int n;
      insert_coin(4'd2);
      insert_coin(4'd2);
      insert_coin(4'd1);
      assert_cnt++;
      if (credit !== 4'd5) begin
         $display("FAIL exact_credit: credit=%0d expected 5", credit);
         fail_cnt++;
      end
      do_buy(2'd2);
      assert_cnt++;
      if (dispense_active !== 1'b1 || credit !== 4'd0 || sel_error !== 1'b0) begin
         $display("FAIL exact_buy_start: da=%b credit=%0d se=%b expected 1/0/0", dispense_active, credit, sel_error);
         fail_cnt++;
      end
      n = 0;
      while (dispense_active === 1'b1 && n < 200) begin
         n++;
         step();
      end
      assert_cnt++;
      if (n != 50) begin
         $display("FAIL exact_dispense_len: %0d cycles expected 50", n);
         fail_cnt++;
      end
      assert_cnt++;
      if (state_dbg !== 2'd2 || change_valid !== 1'b0) begin
         $display("FAIL exact_payout: state=%0d cv=%b expected 2/0", state_dbg, change_valid);
         fail_cnt++;
      end
      step();
      assert_cnt++;
      if (state_dbg !== 2'd0) begin
         $display("FAIL exact_return: state=%0d expected 0", state_dbg);
         fail_cnt++;
      end
   endtask

   task automatic test_change();
      int n;
      insert_coin(4'd4);
      insert_coin(4'd4);
      exp_q.push_back(4'd1);
      do_buy(2'd3);
      n = 0;
      while (dispense_active === 1'b1 && n < 200) begin
         n++;
         step();
      end
      assert_cnt++;
      if (n != 50) begin
         $display("FAIL change_dispense_len: %0d cycles expected 50", n);
         fail_cnt++;
      end
      assert_cnt++;
      if (change_valid !== 1'b1 || change !== 4'd1 || credit !== 4'd0) begin
         $display("FAIL change_payout: cv=%b change=%0d credit=%0d expected 1/1/0", change_valid, change, credit);
         fail_cnt++;
      end
      step();
      assert_cnt++;
      if (change_valid !== 1'b0 || state_dbg !== 2'd0 || change !== 4'd1) begin
         $display("FAIL change_after: cv=%b state=%0d change=%0d expected 0/0/1 (held)", change_valid, state_dbg, change);
         fail_cnt++;
      end
   endtask

   task automatic test_sel_error();
      do_cancel();
      assert_cnt++;
      if (state_dbg !== 2'd0) begin
         $display("FAIL cancel_empty: state=%0d expected 0", state_dbg);
         fail_cnt++;
      end
      insert_coin(4'd3);
      do_buy(2'd1);
      assert_cnt++;
      if (sel_error !== 1'b1 || credit !== 4'd3 || state_dbg !== 2'd0) begin
         $display("FAIL sel_error_pulse: se=%b credit=%0d state=%0d expected 1/3/0", sel_error, credit, state_dbg);
         fail_cnt++;
      end
      step();
      assert_cnt++;
      if (sel_error !== 1'b0) begin
         $display("FAIL sel_error_width: se=%b expected 0", sel_error);
         fail_cnt++;
      end
      exp_q.push_back(4'd3);
      do_cancel();
      assert_cnt++;
      if (change_valid !== 1'b1 || change !== 4'd3 || credit !== 4'd0) begin
         $display("FAIL cancel_refund: cv=%b change=%0d credit=%0d expected 1/3/0", change_valid, change, credit);
         fail_cnt++;
      end
      step();
   endtask

   task automatic test_coin_reject();
      int n;
      insert_coin(4'd7);
      insert_coin(4'd7);
      insert_coin(4'd3);
      assert_cnt++;
      if (coin_reject !== 1'b1 || credit !== 4'd14) begin
         $display("FAIL overflow_reject: cr=%b credit=%0d expected 1/14", coin_reject, credit);
         fail_cnt++;
      end
      insert_coin(4'd1);
      assert_cnt++;
      if (coin_reject !== 1'b0 || credit !== 4'd15) begin
         $display("FAIL max_credit: cr=%b credit=%0d expected 0/15", coin_reject, credit);
         fail_cnt++;
      end
      // buy and coin in the same cycle: buy wins, coin is refused
      exp_q.push_back(4'd12);
      coin_valid = 1'b1;
      coin_value = 4'd1;
      buy = 1'b1;
      product_sel = 2'd0;
      step();
      coin_valid = 1'b0;
      buy = 1'b0;
      assert_cnt++;
      if (coin_reject !== 1'b1 || dispense_active !== 1'b1 || credit !== 4'd0) begin
         $display("FAIL buy_coin_same: cr=%b da=%b credit=%0d expected 1/1/0", coin_reject, dispense_active, credit);
         fail_cnt++;
      end
      step();
      insert_coin(4'd2);
      assert_cnt++;
      if (coin_reject !== 1'b1 || credit !== 4'd0) begin
         $display("FAIL dispense_coin: cr=%b credit=%0d expected 1/0", coin_reject, credit);
         fail_cnt++;
      end
      n = 0;
      while (state_dbg !== 2'd2 && n < 200) begin
         n++;
         step();
      end
      assert_cnt++;
      if (change_valid !== 1'b1 || change !== 4'd12) begin
         $display("FAIL reject_payout: cv=%b change=%0d expected 1/12", change_valid, change);
         fail_cnt++;
      end
      step();
   endtask

   task automatic test_reset_mid_dispense();
      insert_coin(4'd4);
      do_buy(2'd0);
      repeat (19) step();
      assert_cnt++;
      if (dispense_active !== 1'b1) begin
         $display("FAIL mid_dispense_before: da=%b expected 1", dispense_active);
         fail_cnt++;
      end
      #2 rst_n = 1'b0;
      #1;
      assert_cnt++;
      if ({credit, change, change_valid, dispense_active, coin_reject, sel_error, state_dbg} !== 14'd0) begin
         $display("FAIL mid_dispense_reset: credit=%0d change=%0d cv=%b da=%b cr=%b se=%b st=%0d expected all 0",
                  credit, change, change_valid, dispense_active, coin_reject, sel_error, state_dbg);
         fail_cnt++;
      end
      #3 rst_n = 1'b1;
      step();
      repeat (3) step();
      assert_cnt++;
      if (state_dbg !== 2'd0 || credit !== 4'd0 || dispense_active !== 1'b0) begin
         $display("FAIL mid_dispense_after: state=%0d credit=%0d da=%b expected 0/0/0", state_dbg, credit, dispense_active);
         fail_cnt++;
      end
   endtask

   task automatic test_timeout();
      insert_coin(4'd2);
`ifdef REFUND_TIMEOUT_EN
      repeat (255) step();
      assert_cnt++;
      if (state_dbg !== 2'd0 || credit !== 4'd2) begin
         $display("FAIL timeout_early: state=%0d credit=%0d expected 0/2", state_dbg, credit);
         fail_cnt++;
      end
      exp_q.push_back(4'd2);
      step();
      assert_cnt++;
      if (change_valid !== 1'b1 || change !== 4'd2 || credit !== 4'd0) begin
         $display("FAIL timeout_refund: cv=%b change=%0d credit=%0d expected 1/2/0", change_valid, change, credit);
         fail_cnt++;
      end
      step();
`else
      repeat (300) step();
      assert_cnt++;
      if (state_dbg !== 2'd0 || credit !== 4'd2) begin
         $display("FAIL no_timeout: state=%0d credit=%0d expected 0/2", state_dbg, credit);
         fail_cnt++;
      end
      exp_q.push_back(4'd2);
      do_cancel();
      step();
`endif
   endtask

   initial begin
      test_reset();
      test_exact_buy();
      test_change();
      test_sel_error();
      test_coin_reject();
      test_reset_mid_dispense();
      test_timeout();
      repeat (3) step();
      assert_cnt++;
      if (exp_q.size() != 0) begin
         $display("FAIL payout_missing: %0d expected payouts never seen", exp_q.size());
         fail_cnt++;
      end
      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
